// File: rtl/hud_state_ctrl.sv
// ============================================================================
// hud_state_ctrl : game-flow FSM driving BCD score, player, timer and winner
//                  digits for a two-player memory-match HUD.
// Option macro   : HUD_RELOAD_ON_HIT_EN (a hit also restarts the turn timer)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module hud_state_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int TURN_SECS = 15,
  parameter int PAIRS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       match_valid,
  input  logic       match_hit,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] cur_player,
  output logic [3:0] timer_tens,
  output logic [3:0] timer_ones,
  output logic [3:0] winner,
  output logic       game_over
);

  localparam int              c_pw        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_pw-1:0] c_presc_max = c_pw'(CLK_HZ - 1);
  localparam logic [3:0]      c_tens      = 4'(TURN_SECS / 10);
  localparam logic [3:0]      c_ones      = 4'(TURN_SECS % 10);
  localparam logic [4:0]      c_pairs     = 5'(PAIRS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t          r_state, w_nxt_state;
  logic [c_pw-1:0] r_presc, w_nxt_presc;
  logic [3:0]      r_p1, w_nxt_p1;
  logic [3:0]      r_p2, w_nxt_p2;
  logic [3:0]      r_cur, w_nxt_cur;
  logic [3:0]      r_tens, w_nxt_tens;
  logic [3:0]      r_ones, w_nxt_ones;
  logic [3:0]      r_winner, w_nxt_winner;
  logic            r_game_over, w_nxt_game_over;
  logic            w_tick;
  logic [4:0]      w_sum;
  logic [3:0]      w_other;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_presc     <= '0;
      r_p1        <= 4'd0;
      r_p2        <= 4'd0;
      r_cur       <= 4'd1;
      r_tens      <= c_tens;
      r_ones      <= c_ones;
      r_winner    <= 4'd0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_presc     <= w_nxt_presc;
      r_p1        <= w_nxt_p1;
      r_p2        <= w_nxt_p2;
      r_cur       <= w_nxt_cur;
      r_tens      <= w_nxt_tens;
      r_ones      <= w_nxt_ones;
      r_winner    <= w_nxt_winner;
      r_game_over <= w_nxt_game_over;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_presc     = r_presc;
    w_nxt_p1        = r_p1;
    w_nxt_p2        = r_p2;
    w_nxt_cur       = r_cur;
    w_nxt_tens      = r_tens;
    w_nxt_ones      = r_ones;
    w_nxt_winner    = r_winner;
    w_nxt_game_over = r_game_over;
    w_tick          = (r_state == PLAY) && (r_presc == c_presc_max);
    w_other         = (r_cur == 4'd1) ? 4'd2 : 4'd1;
    w_sum           = 5'd0;

    case (r_state)
      PLAY: begin
        w_nxt_presc = w_tick ? '0 : r_presc + 1'b1;
        // A guess outranks a same-cycle tick: the tick is simply dropped.
        if (match_valid) begin
          if (match_hit) begin
            if (r_cur == 4'd1) begin
              w_nxt_p1 = (r_p1 < 4'd9) ? r_p1 + 4'd1 : r_p1;
            end else begin
              w_nxt_p2 = (r_p2 < 4'd9) ? r_p2 + 4'd1 : r_p2;
            end
`ifdef HUD_RELOAD_ON_HIT_EN
            w_nxt_tens  = c_tens;
            w_nxt_ones  = c_ones;
            w_nxt_presc = '0;
`endif
          end else begin
            w_nxt_cur   = w_other;
            w_nxt_tens  = c_tens;
            w_nxt_ones  = c_ones;
            w_nxt_presc = '0;
          end
        end else if (w_tick) begin
          if (r_tens == 4'd0 && r_ones == 4'd1) begin
            w_nxt_cur  = w_other;
            w_nxt_tens = c_tens;
            w_nxt_ones = c_ones;
          end else if (r_ones == 4'd0) begin
            w_nxt_ones = 4'd9;
            w_nxt_tens = r_tens - 4'd1;
          end else begin
            w_nxt_ones = r_ones - 4'd1;
          end
        end

        // End of game is judged on the scores being written this edge.
        w_sum = {1'b0, w_nxt_p1} + {1'b0, w_nxt_p2};
        if (w_sum >= c_pairs) begin
          w_nxt_state     = OVER;
          w_nxt_game_over = 1'b1;
          if (w_nxt_p1 > w_nxt_p2) begin
            w_nxt_winner = 4'd1;
          end else if (w_nxt_p2 > w_nxt_p1) begin
            w_nxt_winner = 4'd2;
          end else begin
            w_nxt_winner = 4'd0;
          end
        end
      end

      default: begin
        if (r_state == IDLE) begin
          w_nxt_presc = '0;
        end
        if (start) begin
          w_nxt_state     = PLAY;
          w_nxt_p1        = 4'd0;
          w_nxt_p2        = 4'd0;
          w_nxt_cur       = 4'd1;
          w_nxt_winner    = 4'd0;
          w_nxt_game_over = 1'b0;
          w_nxt_tens      = c_tens;
          w_nxt_ones      = c_ones;
          w_nxt_presc     = '0;
        end
      end
    endcase
  end

  assign p1_score   = r_p1;
  assign p2_score   = r_p2;
  assign cur_player = r_cur;
  assign timer_tens = r_tens;
  assign timer_ones = r_ones;
  assign winner     = r_winner;
  assign game_over  = r_game_over;

endmodule

`default_nettype wire
